// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, default header base and width helper for uart_tx_arb
package uart_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_DATA = 2'd2} state_t;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin selector (req, ptr -> one-hot pick and id of first req above ptr, wrapping)
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] id
);
  logic [N-1:0] w_rot;
  int w_off;
  int w_sel;
  always_comb begin
    w_rot = N'({req, req} >> (int'(ptr) + 1));
    w_off = 0;
    for (int i = N - 1; i >= 0; i--) if (w_rot[i]) w_off = i;
    w_sel = (w_off + int'(ptr) + 1) % N;
    for (int i = 0; i < N; i++) pick[i] = |req && (i == w_sel);
    id = W'(w_sel);
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet round-robin arbiter onto the UART TX FIFO write port (req/data/last in; ack, tx_fifo_wen/wdata, grant, busy, pkt_done, timeout_err out)
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int HDR_EN = 1,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]   last,
  output logic [N_REQ-1:0]   ack,
  input  logic               tx_fifo_full,
  output logic               tx_fifo_wen,
  output logic [7:0]         tx_fifo_wdata,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               pkt_done,
  output logic               timeout_err
);
  localparam int TW = clog2(TIMEOUT) + 1;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_id, r_ptr, w_pick_id;
  logic [N_REQ-1:0] w_pick;
  logic [TW-1:0] r_timer;
  logic [7:0] w_byte [N_REQ];
  logic w_req, w_last, w_to;
  for (genvar g = 0; g < N_REQ; g++) begin : g_byte
    assign w_byte[g] = data[8*g +: 8];
  end
  assign w_req = req[r_id];
  assign w_last = last[r_id];
  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .pick(w_pick),
    .id  (w_pick_id)
  );
  always_comb begin
    w_next = r_state;
    tx_fifo_wen = 1'b0;
    tx_fifo_wdata = 8'd0;
    w_to = 1'b0;
    case (r_state)
      ST_IDLE: w_next = (en && |req) ? ((HDR_EN != 0) ? ST_HDR : ST_DATA) : ST_IDLE;
      ST_HDR: begin
        tx_fifo_wen = !tx_fifo_full;
        tx_fifo_wdata = HDR_BASE | 8'(r_id);
        w_next = tx_fifo_full ? ST_HDR : ST_DATA;
      end
      ST_DATA: begin
        tx_fifo_wen = w_req && !tx_fifo_full;
        tx_fifo_wdata = w_byte[r_id];
        w_to = !w_req && r_timer == TW'(TIMEOUT - 1);
        w_next = ((tx_fifo_wen && w_last) || w_to) ? ST_IDLE : ST_DATA;
      end
      default: w_next = ST_IDLE;
    endcase
    tx_fifo_wen = tx_fifo_wen && !rst;
  end
  assign ack = (tx_fifo_wen && r_state == ST_DATA) ? grant : '0;
  // timer only advances while the owner is silent; a full FIFO with req high holds it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id <= '0;
      r_ptr <= '0;
      r_timer <= '0;
      grant <= '0;
      busy <= 1'b0;
      pkt_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      busy <= w_next != ST_IDLE;
      pkt_done <= r_state == ST_DATA && tx_fifo_wen && w_last;
      timeout_err <= w_to;
      r_timer <= (r_state != ST_DATA || tx_fifo_wen) ? '0 : r_timer + TW'(!w_req);
      if (r_state == ST_IDLE) begin
        grant <= en ? w_pick : '0;
        r_id <= w_pick_id;
      end else if (w_next == ST_IDLE) begin
        grant <= '0;
        r_ptr <= r_id;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb (byte stream, grant order, stall, timeout, en gating, reset)
module tb_uart_tx_arb;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, en, tx_fifo_full;
  logic [N-1:0] req, last, ack, grant;
  logic [8*N-1:0] data;
  logic tx_fifo_wen, busy, pkt_done, timeout_err;
  logic [7:0] tx_fifo_wdata;
  always #5 clk = ~clk;
  uart_tx_arb #(.N_REQ(4), .ID_W(2), .HDR_EN(1), .HDR_BASE(8'hA0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .data(data), .last(last), .ack(ack),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_wen(tx_fifo_wen), .tx_fifo_wdata(tx_fifo_wdata),
    .grant(grant), .busy(busy), .pkt_done(pkt_done), .timeout_err(timeout_err)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int wr_cyc[$];
  int gnt_cyc[$];
  logic [N-1:0] gnt_val[$];
  int ack_cnt[N];
  int done_cnt = 0;
  int to_cnt = 0;
  int to_cyc = 0;
  logic [N-1:0] to_gnt = '0;
  logic [N-1:0] ack_seen = '0;
  logic [N-1:0] prev_gnt = '0;
  logic [8:0] src [N][32];
  int wp[N];
  int rp[N];
  int ord[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int wcyc(input int k);
    return (k < wr_cyc.size()) ? wr_cyc[k] : -1;
  endfunction
  function automatic int gcyc(input int k);
    return (k < gnt_cyc.size()) ? gnt_cyc[k] : -1;
  endfunction
  function automatic int gval(input int k);
    return (k < gnt_val.size()) ? int'(gnt_val[k]) : -1;
  endfunction
  task automatic put(input int i, input logic [7:0] b, input logic l);
    src[i][wp[i] % 32] = {l, b};
    wp[i]++;
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_q.size(), 0);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    ack_seen = ack;
    for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    if (tx_fifo_full) check("full_stall", {30'd0, tx_fifo_wen, |ack}, 0);
    if (|ack) begin
      check("ack_wen", 32'(tx_fifo_wen), 1);
      check("ack_grant", 32'(ack), 32'(grant));
    end
    if (tx_fifo_wen) begin
      wr_cyc.push_back(cyc);
      check("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("wdata", 32'(tx_fifo_wdata), 32'(exp_q.pop_front()));
    end
    if (pkt_done) done_cnt++;
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
      to_gnt = grant;
    end
    if (grant != '0 && grant != prev_gnt) begin
      gnt_cyc.push_back(cyc);
      gnt_val.push_back(grant);
    end
    prev_gnt = grant;
  end
  // requester model: each requester streams its buffer, advancing on ack
  initial begin
    req = '0;
    data = '0;
    last = '0;
    for (int i = 0; i < N; i++) for (int k = 0; k < 32; k++) src[i][k] = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) if (ack_seen[i]) rp[i]++;
      #1;
      for (int i = 0; i < N; i++) begin
        req[i] = rp[i] != wp[i];
        data[8*i +: 8] = src[i][rp[i] % 32][7:0];
        last[i] = src[i][rp[i] % 32][8];
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int t0, a0, d0, w0, g0, s0, ec;
    rst = 1'b1;
    en = 1'b1;
    tx_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(pkt_done), 0);
    check("rst_to", 32'(timeout_err), 0);
    check("rst_wen", 32'(tx_fifo_wen), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_wdata", 32'(tx_fifo_wdata), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    // single 3-byte packet from requester 2
    t0 = cyc; a0 = ack_cnt[2]; d0 = done_cnt; w0 = wr_cyc.size();
    exp_q.push_back(8'hA2); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    put(2, 8'h11, 0); put(2, 8'h22, 0); put(2, 8'h33, 1);
    drain("t1_drain");
    check("t1_ack_cnt", ack_cnt[2] - a0, 3);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_writes", wr_cyc.size() - w0, 4);
    check("t1_arb_lat", wcyc(w0) - t0, 2);
    check("t1_back2back", wcyc(w0 + 3) - wcyc(w0), 3);
    check("t1_busy_end", 32'(busy), 0);
    // all requesters with two 1-byte packets each, ptr=0 after reset
    do_reset();
    g0 = gnt_val.size();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(8'hA0 | 8'(ord[k]));
      exp_q.push_back(8'h50 + 8'(4 * ord[k] + k / 4));
    end
    for (int i = 0; i < N; i++) for (int n = 0; n < 2; n++) put(i, 8'h50 + 8'(4 * i + n), 1);
    drain("t2_drain");
    for (int k = 0; k < 5; k++) check("t2_grant_order", gval(g0 + k), 1 << ord[k]);
    // FIFO full stalls mid-packet (5 cycles, then 9 cycles) from requester 3
    a0 = ack_cnt[3]; s0 = to_cnt;
    exp_q.push_back(8'hA3);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(8'h30 + 8'(k));
      put(3, 8'h30 + 8'(k), k == 6);
    end
    for (int t = 0; t < 50 && ack_cnt[3] < a0 + 1; t++) @(posedge clk);
    #1 tx_fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 tx_fifo_full = 1'b0;
    for (int t = 0; t < 50 && ack_cnt[3] < a0 + 3; t++) @(posedge clk);
    #1 tx_fifo_full = 1'b1;
    repeat (9) @(posedge clk);
    #1 tx_fifo_full = 1'b0;
    drain("t3_drain");
    check("t3_no_timeout", to_cnt - s0, 0);
    check("t3_ack_cnt", ack_cnt[3] - a0, 6);
    // requester 0 goes silent after one byte; requester 1 waits
    w0 = wr_cyc.size(); s0 = to_cnt;
    exp_q.push_back(8'hA0); exp_q.push_back(8'h0A); exp_q.push_back(8'hA1); exp_q.push_back(8'h1B);
    put(0, 8'h0A, 0);
    put(1, 8'h1B, 1);
    drain("t4_drain");
    check("t4_to_cnt", to_cnt - s0, 1);
    // byte sampled in cycle w is accepted at the edge opening cycle w+1; pulse 8 edges later
    check("t4_to_delay", to_cyc - (wcyc(w0 + 1) + 1), 8);
    check("t4_to_grant", 32'(to_gnt), 0);
    check("t4_next_grant", gval(gnt_val.size() - 1), 2);
    check("t4_next_lat", gcyc(gnt_cyc.size() - 1) - to_cyc, 1);
    // en dropped during requester 1 packet; requester 3 must wait for en
    a0 = ack_cnt[1]; d0 = done_cnt;
    exp_q.push_back(8'hA1); exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    put(1, 8'h61, 0); put(1, 8'h62, 0); put(1, 8'h63, 1);
    for (int t = 0; t < 50 && ack_cnt[1] == a0; t++) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    put(3, 8'h71, 1);
    for (int t = 0; t < 50 && done_cnt == d0; t++) @(negedge clk);
    w0 = wr_cyc.size();
    repeat (6) @(negedge clk);
    check("t5_ack_cnt", ack_cnt[1] - a0, 3);
    check("t5_pkt_done", done_cnt - d0, 1);
    check("t5_hold_grant", 32'(grant), 0);
    check("t5_hold_busy", 32'(busy), 0);
    check("t5_hold_writes", wr_cyc.size() - w0, 0);
    g0 = gnt_cyc.size();
    @(posedge clk);
    #1 en = 1'b1;
    ec = cyc;
    exp_q.push_back(8'hA3); exp_q.push_back(8'h71);
    drain("t5_drain");
    check("t5_grant_val", gval(g0), 8);
    check("t5_grant_lat", gcyc(g0) - ec, 1);
    // reset in the middle of a requester 2 packet
    a0 = ack_cnt[2];
    exp_q.push_back(8'hA2); exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    for (int k = 1; k <= 5; k++) put(2, 8'h80 + 8'(k), k == 5);
    for (int t = 0; t < 50 && ack_cnt[2] < a0 + 2; t++) @(posedge clk);
    #2 rst = 1'b1;
    rp[2] = wp[2];
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 0);
    check("t6_grant", 32'(grant), 0);
    check("t6_wen", 32'(tx_fifo_wen), 0);
    check("t6_partial", exp_q.size(), 0);
    g0 = gnt_val.size();
    exp_q.push_back(8'hA3); exp_q.push_back(8'h93); exp_q.push_back(8'hA0); exp_q.push_back(8'h90);
    put(0, 8'h90, 1);
    put(3, 8'h93, 1);
    drain("t6_drain");
    check("t6_first_grant", gval(g0), 8);
    check("t6_second_grant", gval(g0 + 1), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
